// File: rtl/fact_accel_if.sv
// Data-bus slave interface for the factorial accelerator:
// store strobe, word address and write data in; load data and done level out.
interface fact_accel_if #(
    parameter int unsigned WIDTH = 32
);
    logic             we;
    logic [1:0]       a;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] rd;
    logic             irq_done;

    modport master (output we, a, wd, input rd, irq_done);
    modport slave  (input we, a, wd, output rd, irq_done);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator.
// Register map: 0=N (RW), 1=GO (WO, reads 0), 2=STATUS {busy,err,done}, 3=RESULT.
// One multiply per clock while in CALC; n > MAX_N takes a single-cycle error path.
module fact_accel #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NW    = 4,
    parameter int unsigned MAX_N = 12
) (
    input logic         clk,
    input logic         rst,
    fact_accel_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [NW-1:0]    n_q, n_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             wr_n;
    logic             wr_go;
    logic [WIDTH-1:0] mul;

    assign wr_n  = bus.we && (bus.a == 2'd0);
    assign wr_go = bus.we && (bus.a == 2'd1) && bus.wd[0];

    // Low WIDTH bits of prod*cnt; cnt is zero-extended to WIDTH.
    assign mul = prod_q * {{(WIDTH-NW){1'b0}}, cnt_q};

    // State and datapath registers; reset wins over any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath update: N writes in any state, GO only outside CALC.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        result_d = result_q;
        done_d   = done_q;
        err_d    = err_q;
        busy_d   = busy_q;

        if (wr_n) begin
            n_d = bus.wd[NW-1:0];
        end

        case (state_q)
            IDLE, DONE: begin
                if (wr_go) begin
                    done_d = 1'b0;
                    if (32'(n_q) > MAX_N) begin
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        prod_d  = WIDTH'(1);
                        cnt_d   = n_q;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q <= NW'(1)) begin
                    result_d = prod_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    prod_d = mul;
                    cnt_d  = cnt_q - NW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational read mux, no side effects.
    always_comb begin
        bus.rd = '0;
        case (bus.a)
            2'd0: bus.rd = {{(WIDTH-NW){1'b0}}, n_q};
            2'd1: bus.rd = '0;
            2'd2: bus.rd = {{(WIDTH-3){1'b0}}, busy_q, err_q, done_q};
            2'd3: bus.rd = result_q;
            default: bus.rd = '0;
        endcase
    end

    assign bus.irq_done = done_q;

endmodule
